// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage with wait-stated word RAM, branch/jump redirect and MEM/WB register; MEM_ALIGN_CHECK_EN enables misalignment checking
module mem_wb_stage #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic [4:0]  regRd_in,
  input  logic [31:0] memadd_in,
  input  logic [31:0] Wrdata_in,
  input  logic        Branch_in,
  input  logic        ALUzero_in,
  input  logic [31:0] branchpc_in,
  input  logic        Jump_in,
  input  logic [31:0] jumpaddr_in,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] pc_target,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [4:0]  regRd_out,
  output logic [31:0] memdata_out,
  output logic [31:0] aluresult_out,
  output logic        align_err
);
  typedef enum logic {IDLE, BUSY} state_e;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           ram_q [2**DEPTH_LOG2];
  logic                  access, mis, hold;
  logic [DEPTH_LOG2-1:0] idx;
  assign access = MemRead_in | MemWrite_in;
  assign idx    = memadd_in[DEPTH_LOG2+1:2];
`ifdef MEM_ALIGN_CHECK_EN
  assign mis = access && (memadd_in[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  // hold is the raw wait-state stall; outputs are forced low while reset is asserted
  assign hold      = (state_q == IDLE) ? (access && (WAIT_CYCLES != 0)) : (cnt_q != 4'd0);
  assign stall     = rst_n && hold;
  assign redirect  = rst_n && !hold && (Jump_in || (Branch_in && ALUzero_in));
  assign pc_target = !redirect ? 32'd0 : Jump_in ? jumpaddr_in : branchpc_in;
  // wait-state sequencer next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      state_d = (access && (WAIT_CYCLES != 0)) ? BUSY : IDLE;
      cnt_d   = (access && (WAIT_CYCLES != 0)) ? CNT_INIT : cnt_q;
    end else begin
      state_d = (cnt_q == 4'd0) ? IDLE : BUSY;
      cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    end
  end
  // wait-state sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // RAM store on the completion edge only; reset drops a pending store
  always_ff @(posedge clk) begin
    if (rst_n && MemWrite_in && !hold && !mis) ram_q[idx] <= Wrdata_in;
  end
  // MEM/WB register: bubble while stalled, load data captured on load completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_out  <= 1'b0;
      MemtoReg_out  <= 1'b0;
      regRd_out     <= 5'd0;
      memdata_out   <= 32'd0;
      aluresult_out <= 32'd0;
    end else if (hold) begin
      RegWrite_out <= 1'b0;
      MemtoReg_out <= 1'b0;
    end else begin
      RegWrite_out  <= RegWrite_in;
      MemtoReg_out  <= MemtoReg_in;
      regRd_out     <= regRd_in;
      aluresult_out <= memadd_in;
      if (MemRead_in) memdata_out <= mis ? 32'd0 : ram_q[idx];
    end
  end
`ifdef MEM_ALIGN_CHECK_EN
  // sticky misalignment flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) align_err <= 1'b0;
    else if (mis) align_err <= 1'b1;
  end
`else
  assign align_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench driving a zero-wait and a two-wait instance with shared stimulus
module tb_mem_wb_stage;
  localparam int WW = 2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic MemRead_in = 0, MemWrite_in = 0, MemtoReg_in = 0, RegWrite_in = 0;
  logic Branch_in = 0, ALUzero_in = 0, Jump_in = 0;
  logic [4:0] regRd_in = 0;
  logic [31:0] memadd_in = 0, Wrdata_in = 0, branchpc_in = 0, jumpaddr_in = 0;
  logic stall0, redirect0, rw0, mr0, ae0, stallw, redirectw, rww, mrw, aew;
  logic [4:0] rd0, rdw;
  logic [31:0] pc0, md0, alu0, pcw, mdw, aluw;
  logic [31:0] m0 [256];
  logic [31:0] mw [256];
  logic [31:0] q0[$], qw[$];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_wb_stage #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .regRd_in(regRd_in),
    .memadd_in(memadd_in), .Wrdata_in(Wrdata_in), .Branch_in(Branch_in), .ALUzero_in(ALUzero_in),
    .branchpc_in(branchpc_in), .Jump_in(Jump_in), .jumpaddr_in(jumpaddr_in),
    .stall(stall0), .redirect(redirect0), .pc_target(pc0), .RegWrite_out(rw0),
    .MemtoReg_out(mr0), .regRd_out(rd0), .memdata_out(md0), .aluresult_out(alu0), .align_err(ae0));
  mem_wb_stage #(.DEPTH_LOG2(8), .WAIT_CYCLES(WW)) dutw (
    .clk(clk), .rst_n(rst_n), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .regRd_in(regRd_in),
    .memadd_in(memadd_in), .Wrdata_in(Wrdata_in), .Branch_in(Branch_in), .ALUzero_in(ALUzero_in),
    .branchpc_in(branchpc_in), .Jump_in(Jump_in), .jumpaddr_in(jumpaddr_in),
    .stall(stallw), .redirect(redirectw), .pc_target(pcw), .RegWrite_out(rww),
    .MemtoReg_out(mrw), .regRd_out(rdw), .memdata_out(mdw), .aluresult_out(aluw), .align_err(aew));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle_inputs();
    MemRead_in = 0; MemWrite_in = 0; MemtoReg_in = 0; RegWrite_in = 0;
    Branch_in = 0; ALUzero_in = 0; Jump_in = 0; branchpc_in = 0; jumpaddr_in = 0;
  endtask
  task automatic mem_op(input bit ld, input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd, input bit jmp);
    int ns;
    bit st, done, mis;
    logic [7:0] i;
    @(negedge clk);
    idle_inputs();
    MemRead_in = ld; MemWrite_in = !ld; MemtoReg_in = ld; RegWrite_in = ld;
    regRd_in = rd; memadd_in = a; Wrdata_in = d; Jump_in = jmp; jumpaddr_in = 32'h80;
    mis = ALIGN && (a[1:0] != 2'b00);
    i = a[9:2];
    if (ld) begin
      q0.push_back(mis ? 32'd0 : m0[i]);
      qw.push_back(mis ? 32'd0 : mw[i]);
    end else if (!mis) begin
      m0[i] = d;
      mw[i] = d;
    end
    #1;
    chk("stall0", {31'd0, stall0}, 32'd0);
    chk("redirect0", {31'd0, redirect0}, {31'd0, jmp});
    ns = 0;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      st = stallw;
      chk("redirect_w", {31'd0, redirectw}, {31'd0, !st && jmp});
      @(posedge clk);
      #1;
      if (k == 0) begin
        chk("regwrite0", {31'd0, rw0}, {31'd0, ld});
        chk("regrd0", {27'd0, rd0}, {27'd0, rd});
        chk("alu0", alu0, a);
        if (ld) chk("memdata0", md0, q0.pop_front());
      end
      if (st) begin
        ns++;
        chk("bubble_w", {31'd0, rww}, 32'd0);
      end else begin
        done = 1;
        chk("regwrite_w", {31'd0, rww}, {31'd0, ld});
        if (ld) chk("memdata_w", mdw, qw.pop_front());
      end
    end
    if (!done) chk("timeout_w", 32'd0, 32'd1);
    chk("stall_cycles_w", 32'(ns), 32'(WW));
    @(negedge clk);
    idle_inputs();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, {30'd0, stall0, stallw}, 32'd0);
    chk({tag, "_redirect"}, {30'd0, redirect0, redirectw}, 32'd0);
    chk({tag, "_ctl"}, {24'd0, rw0, rww, mr0, mrw, ae0, aew, 2'b00}, 32'd0);
    chk({tag, "_regrd"}, {22'd0, rd0, rdw}, 32'd0);
    chk({tag, "_data"}, md0 | mdw | alu0 | aluw | pc0 | pcw, 32'd0);
  endtask
  task automatic br(input bit b, input bit z, input bit j, input bit er, input logic [31:0] et);
    @(negedge clk);
    Branch_in = b; ALUzero_in = z; Jump_in = j; branchpc_in = 32'h40; jumpaddr_in = 32'h80;
    #1;
    chk("br_redirect0", {31'd0, redirect0}, {31'd0, er});
    chk("br_target0", pc0, et);
    chk("br_redirect_w", {31'd0, redirectw}, {31'd0, er});
    chk("br_target_w", pcw, et);
    idle_inputs();
  endtask
  initial begin
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    mem_op(0, 32'h10, 32'hDEADBEEF, 5'd0, 0);
    mem_op(1, 32'h10, 32'h0, 5'd5, 0);
    chk("wb_regrd_w", {27'd0, rdw}, 32'd5);
    mem_op(0, 32'h400, 32'h12345678, 5'd0, 0);
    mem_op(1, 32'h0, 32'h0, 5'd7, 0);
    br(1, 1, 0, 1, 32'h40);
    br(1, 1, 1, 1, 32'h80);
    br(1, 0, 0, 0, 32'h0);
    br(0, 0, 1, 1, 32'h80);
    mem_op(1, 32'h10, 32'h0, 5'd9, 1);
    mem_op(0, 32'h13, 32'hCAFEF00D, 5'd0, 0);
    chk("align_err0", {31'd0, ae0}, {31'd0, ALIGN});
    chk("align_err_w", {31'd0, aew}, {31'd0, ALIGN});
    mem_op(1, 32'h10, 32'h0, 5'd3, 0);
    mem_op(0, 32'h20, 32'hAAAA5555, 5'd0, 0);
    @(negedge clk);
    MemWrite_in = 1; memadd_in = 32'h20; Wrdata_in = 32'h11112222;
    m0[8] = 32'h11112222;
    @(posedge clk);
    #1;
    chk("busy_stall_w", {31'd0, stallw}, 32'd1);
    #1;
    rst_n = 0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    mem_op(1, 32'h20, 32'h0, 5'd4, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
